// File: rtl/bitcell_pkg.sv
// Shared definitions for the bitcell latch-array write scheduler.
package bitcell_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
    HOLD   = 3'd3,
    CAPT   = 3'd4,
    VERIFY = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  localparam int DEF_WORDS = 4;
  localparam int DEF_DW    = 4;

endpackage

// File: rtl/bitcell_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that was not served last wins.
module bitcell_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] & (~req[1] | rr_last);
    gnt[1] = req[1] & (~req[0] | ~rr_last);
  end

endmodule

// File: rtl/bitcell_wr_sched.sv
// Round-robin access scheduler for a shared DQ latch array: setup -> enable pulse -> hold.
// Optional write read-back check enabled by defining WR_VERIFY_EN.
module bitcell_wr_sched
  import bitcell_pkg::*;
#(
  parameter int WORDS     = DEF_WORDS,
  parameter int AW        = 2,
  parameter int DW        = DEF_DW,
  parameter int PULSE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          op,
  input  logic [2*AW-1:0]     addr,
  input  logic [2*DW-1:0]     wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [DW-1:0]       rdata,
  output logic                err,
  output logic [DW-1:0]       arr_d,
  output logic [WORDS-1:0]    arr_en,
  input  logic [WORDS*DW-1:0] arr_q
);

  localparam logic [3:0] CNT_RELOAD = 4'(PULSE_CYC - 1);

  state_t           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             win_q, win_d;
  logic             op_q, op_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       gnt_d, done_d;
  logic [DW-1:0]    rdata_d, arr_d_d;
  logic [WORDS-1:0] arr_en_d;
  logic [1:0]       arb_gnt;
  logic [WORDS-1:0] word_hit;
  logic [DW-1:0]    word_q;
  logic             arb_win;
`ifdef WR_VERIFY_EN
  logic             err_q, err_d;
`endif

  bitcell_rr_arb2 u_arb (
    .req     (req),
    .rr_last (rr_last_q),
    .gnt     (arb_gnt)
  );

  // Out-of-range addresses match no word: no enable and a zero read-back.
  always_comb begin
    word_hit = '0;
    word_q   = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (32'(addr_q) == i) begin
        word_hit[i] = 1'b1;
        word_q      = arr_q[i*DW +: DW];
      end
    end
  end

  assign arb_win = arb_gnt[1];

  // Outputs are computed one state ahead so the registered copies line up with the state.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    win_d     = win_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt;
    done_d    = '0;
    rdata_d   = rdata;
    arr_d_d   = arr_d;
    arr_en_d  = '0;
`ifdef WR_VERIFY_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          win_d     = arb_win;
          rr_last_d = arb_win;
          op_d      = op[arb_win];
          addr_d    = arb_win ? addr[2*AW-1:AW] : addr[AW-1:0];
          wdata_d   = arb_win ? wdata[2*DW-1:DW] : wdata[DW-1:0];
          gnt_d     = arb_gnt;
          if (op[arb_win] == OP_WR) arr_d_d = wdata_d;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (op_q == OP_WR) begin
          state_d  = PULSE;
          cnt_d    = CNT_RELOAD;
          arr_en_d = word_hit;
        end else begin
          state_d = CAPT;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          arr_en_d = word_hit;
        end
      end
      HOLD: begin
`ifdef WR_VERIFY_EN
        state_d = VERIFY;
`else
        state_d        = DONE;
        done_d[win_q]  = 1'b1;
`endif
      end
`ifdef WR_VERIFY_EN
      VERIFY: begin
        err_d         = (word_q != wdata_q);
        rdata_d       = word_q;
        state_d       = DONE;
        done_d[win_q] = 1'b1;
      end
`endif
      CAPT: begin
        rdata_d       = word_q;
        state_d       = DONE;
        done_d[win_q] = 1'b1;
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      win_q     <= 1'b0;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      arr_d     <= '0;
      arr_en    <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      win_q     <= win_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      done      <= done_d;
      rdata     <= rdata_d;
      arr_d     <= arr_d_d;
      arr_en    <= arr_en_d;
    end
  end

`ifdef WR_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bitcell_wr_sched.sv
// Scoreboard bench for bitcell_wr_sched driving a 4-word DQ latch array model.
module tb_bitcell_wr_sched;

  localparam int PULSE_CYC = 2;
`ifdef WR_VERIFY_EN
  localparam int WR_LAT = PULSE_CYC + 4;
`else
  localparam int WR_LAT = PULSE_CYC + 3;
`endif
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  op = '0;
  logic [3:0]  addr = '0;
  logic [7:0]  wdata = '0;
  logic [1:0]  gnt, done;
  logic [3:0]  rdata, arr_d;
  logic        err;
  logic [3:0]  arr_en;
  logic [15:0] arr_q;

  logic        stuck = 1'b0;
  logic [3:0]  mem [4];
  logic [3:0]  d_eff [4];

  bitcell_wr_sched #(
    .WORDS     (4),
    .AW        (2),
    .DW        (4),
    .PULSE_CYC (PULSE_CYC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op     (op),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .done   (done),
    .rdata  (rdata),
    .err    (err),
    .arr_d  (arr_d),
    .arr_en (arr_en),
    .arr_q  (arr_q)
  );

  always #5 clk = ~clk;

  // Latch array model; word 1 can have D bit 0 stuck at 0.
  for (genvar g = 0; g < 4; g++) begin : g_word
    assign d_eff[g] = (g == 1 && stuck) ? (arr_d & 4'b1110) : arr_d;
    always_latch begin
      if (arr_en[g]) mem[g] <= d_eff[g];
    end
  end
  assign arr_q = {mem[3], mem[2], mem[1], mem[0]};

  typedef struct {
    int         who;
    int         lat;
    logic [3:0] en;
    int         en_cyc;
    logic       err;
    logic       chk_rd;
    logic [3:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int who, input logic o, input logic [1:0] a, input logic [3:0] d,
                      input logic e_err, input logic chk_rd, input logic [3:0] e_rd);
    exp_t e;
    e.who    = who;
    e.lat    = (o == 1'b1) ? WR_LAT : RD_LAT;
    e.en     = (o == 1'b1) ? (4'b0001 << a) : 4'b0000;
    e.en_cyc = (o == 1'b1) ? PULSE_CYC : 0;
    e.err    = e_err;
    e.chk_rd = chk_rd;
    e.rdata  = e_rd;
    exp_q.push_back(e);
  endtask

  task automatic setup_req(input int who, input logic o, input logic [1:0] a, input logic [3:0] d);
    op[who]           = o;
    addr[who*2 +: 2]  = a;
    wdata[who*4 +: 4] = d;
  endtask

  task automatic single(input int who, input logic o, input logic [1:0] a, input logic [3:0] d,
                        input logic e_err, input logic chk_rd, input logic [3:0] e_rd);
    logic got;
    got = 1'b0;
    push(who, o, a, d, e_err, chk_rd, e_rd);
    setup_req(who, o, a, d);
    req[who] = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (done[who]) got = 1'b1;
    end
    check("done_timeout", 32'(got), 32'd1);
    req[who] = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: latency is counted from the first cycle gnt is high to the done cycle inclusive.
  int         cyc = 0;
  logic       in_acc = 1'b0;
  logic       gap_chk = 1'b0;
  int         start = 0;
  int         en_cnt = 0;
  logic [3:0] en_val = '0;
  logic [1:0] gnt_seen = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      in_acc  = 1'b0;
      gap_chk = 1'b0;
      en_cnt  = 0;
      en_val  = '0;
    end else begin
      if (gap_chk) begin
        check("idle_gap_gnt", 32'(gnt), 32'd0);
        gap_chk = 1'b0;
      end
      if (gnt != 2'b00 && !in_acc) begin
        in_acc   = 1'b1;
        start    = cyc;
        en_cnt   = 0;
        en_val   = '0;
        gnt_seen = gnt;
      end
      if (arr_en != 4'b0000) begin
        en_cnt++;
        en_val = arr_en;
        check("en_without_gnt", 32'(gnt != 2'b00), 32'd1);
      end
      if (done != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_who", 32'(done), 32'(2'b01 << e.who));
          check("gnt_who", 32'(gnt_seen), 32'(2'b01 << e.who));
          check("latency", 32'(cyc - start + 1), 32'(e.lat));
          check("en_cycles", 32'(en_cnt), 32'(e.en_cyc));
          if (e.en_cyc != 0) check("en_pattern", 32'(en_val), 32'(e.en));
          check("err", 32'(err), 32'(e.err));
          if (e.chk_rd) check("rdata", 32'(rdata), 32'(e.rdata));
        end
        in_acc  = 1'b0;
        gap_chk = 1'b1;
      end
    end
  end

  initial begin
    int  dn0, dn1;
    logic seen;

    // 1: reset values and quiet idle
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_arr_en", 32'(arr_en), 32'd0);
    check("rst_arr_d", 32'(arr_d), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_arr_en", 32'(arr_en), 32'd0);
      check("idle_gnt", 32'(gnt), 32'd0);
    end

    // 2: write word 2, then inspect the latch contents
    single(0, 1'b1, 2'd2, 4'b1010, 1'b0, 1'b0, 4'h0);
    check("word2_contents", 32'(mem[2]), 32'h0000_000a);

    // 3: read it back through requester 1
    single(1, 1'b0, 2'd2, 4'h0, 1'b0, 1'b1, 4'b1010);
    @(negedge clk);
    check("rdata_held", 32'(rdata), 32'h0000_000a);

    // 4: both requesters held as writes -> order 0,1,0,1
    push(0, 1'b1, 2'd0, 4'b0011, 1'b0, 1'b0, 4'h0);
    push(1, 1'b1, 2'd1, 4'b1100, 1'b0, 1'b0, 4'h0);
    push(0, 1'b1, 2'd0, 4'b0011, 1'b0, 1'b0, 4'h0);
    push(1, 1'b1, 2'd1, 4'b1100, 1'b0, 1'b0, 4'h0);
    setup_req(0, 1'b1, 2'd0, 4'b0011);
    setup_req(1, 1'b1, 2'd1, 4'b1100);
    req = 2'b11;
    dn0 = 0;
    dn1 = 0;
    for (int k = 0; k < 200 && !(dn0 == 2 && dn1 == 2); k++) begin
      @(negedge clk);
      if (done[0]) dn0++;
      if (done[1]) dn1++;
      if (dn0 == 2) req[0] = 1'b0;
      if (dn1 == 2) req[1] = 1'b0;
    end
    check("contend_done0", 32'(dn0), 32'd2);
    check("contend_done1", 32'(dn1), 32'd2);
    req = 2'b00;
    @(negedge clk);
    single(0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 4'b0011);
    single(1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b1, 4'b1100);

    // 5: reset during the enable pulse
    setup_req(0, 1'b1, 2'd3, 4'b0110);
    req[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (arr_en != 4'b0000) seen = 1'b1;
    end
    check("pulse_reached", 32'(seen), 32'd1);
    rst    = 1'b1;
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_arr_en", 32'(arr_en), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    single(1, 1'b1, 2'd3, 4'b0110, 1'b0, 1'b0, 4'h0);
    single(0, 1'b0, 2'd3, 4'h0, 1'b0, 1'b1, 4'b0110);

`ifdef WR_VERIFY_EN
    // 6: stuck D bit on word 1 is reported, clean writes are not
    stuck = 1'b1;
    single(0, 1'b1, 2'd1, 4'b0001, 1'b1, 1'b1, 4'b0000);
    single(1, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b1, 4'b0010);
    stuck = 1'b0;
    single(0, 1'b1, 2'd2, 4'b0101, 1'b0, 1'b1, 4'b0101);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
